// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_ctrl
//  Brief    : Single-clock SPI master for the SS_n/MOSI/MISO slave RAM wrapper.
//             Serialises {cmd[1:0], data[7:0]} MSB first and captures an 8-bit
//             MISO reply for read-data (cmd=11) frames.
//             Optional one-entry command buffer: define SPI_MASTER_QUEUE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master_ctrl #(
    parameter int RD_LATENCY = 2,
    parameter int IDLE_GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] data_in,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEL   = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_RECV  = 3'd4,
        S_STOP  = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    // Terminal counts; STOP is itself the first SS_n-high cycle of the gap.
    localparam logic [7:0] C_WAIT_LAST   = 8'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);
    localparam logic [7:0] C_GAP_LAST    = 8'((IDLE_GAP > 1) ? IDLE_GAP - 2 : 0);
    localparam bit         C_GAP_IN_STOP = (IDLE_GAP <= 1);
    localparam bit         C_HAS_WAIT    = (RD_LATENCY > 0);

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tmr_q, tmr_d;
    logic [9:0] shift_q, shift_d;
    logic       rd_q, rd_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;

    logic       w_busy;
    logic       w_ready;
    logic       w_accept;
    logic       w_last_gap;
    logic       w_launch;
    logic [9:0] w_launch_word;

    assign w_busy     = (state_q != S_IDLE);
    assign w_last_gap = ((state_q == S_STOP) && C_GAP_IN_STOP) ||
                        ((state_q == S_GAP) && (tmr_q == C_GAP_LAST));
    assign w_accept   = start & w_ready;

`ifdef SPI_MASTER_QUEUE_EN
    logic       buf_full_q, buf_full_d;
    logic [9:0] buf_word_q, buf_word_d;

    assign w_ready = ~buf_full_q;

    // Launch selection and buffer fill/drain; the buffer is always empty in IDLE.
    always_comb begin
        w_launch      = 1'b0;
        w_launch_word = {cmd, data_in};
        buf_full_d    = buf_full_q;
        buf_word_d    = buf_word_q;
        if (state_q == S_IDLE) begin
            w_launch = w_accept;
        end else if (w_last_gap) begin
            if (buf_full_q) begin
                w_launch      = 1'b1;
                w_launch_word = buf_word_q;
                buf_full_d    = 1'b0;
            end else begin
                w_launch = w_accept;
            end
        end else if (w_accept) begin
            buf_full_d = 1'b1;
            buf_word_d = {cmd, data_in};
        end
    end

    // Command buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_full_q <= 1'b0;
            buf_word_q <= 10'd0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_word_q <= buf_word_d;
        end
    end
`else
    assign w_ready       = ~w_busy;
    assign w_launch      = (state_q == S_IDLE) && w_accept;
    assign w_launch_word = {cmd, data_in};
`endif

    // Next-state and datapath updates for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tmr_d      = tmr_q;
        shift_d    = shift_q;
        rd_d       = rd_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        case (state_q)
            S_IDLE: ;
            S_SEL: begin
                // Cycle 0 is the dead cycle, cycle 1 pre-presents cmd[1].
                if (bit_cnt_q == 4'd1) begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = 4'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            S_SHIFT: begin
                shift_d = {shift_q[8:0], 1'b0};
                if (bit_cnt_q == 4'd9) begin
                    bit_cnt_d = 4'd0;
                    tmr_d     = 8'd0;
                    if (!rd_q)           state_d = S_STOP;
                    else if (C_HAS_WAIT) state_d = S_WAIT;
                    else                 state_d = S_RECV;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (tmr_q == C_WAIT_LAST) state_d = S_RECV;
                else                      tmr_d   = tmr_q + 8'd1;
            end
            S_RECV: begin
                rx_shift_d = {rx_shift_q[6:0], MISO};
                if (bit_cnt_q == 4'd7) begin
                    rx_data_d = {rx_shift_q[6:0], MISO};
                    bit_cnt_d = 4'd0;
                    state_d   = S_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            S_STOP: begin
                tmr_d = 8'd0;
                if (C_GAP_IN_STOP) state_d = S_IDLE;
                else               state_d = S_GAP;
            end
            S_GAP: begin
                tmr_d = tmr_q + 8'd1;
                if (w_last_gap) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A launch takes priority over returning to IDLE.
        if (w_launch) begin
            state_d   = S_SEL;
            bit_cnt_d = 4'd0;
            shift_d   = w_launch_word;
            rd_d      = &w_launch_word[9:8];
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 4'd0;
            tmr_q      <= 8'd0;
            shift_q    <= 10'd0;
            rd_q       <= 1'b0;
            rx_shift_q <= 8'd0;
            rx_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tmr_q      <= tmr_d;
            shift_q    <= shift_d;
            rd_q       <= rd_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign SS_n     = ~((state_q == S_SEL) || (state_q == S_SHIFT) ||
                        (state_q == S_WAIT) || (state_q == S_RECV));
    assign MOSI     = (((state_q == S_SEL) && (bit_cnt_q == 4'd1)) ||
                       (state_q == S_SHIFT)) ? shift_q[9] : 1'b0;
    assign busy     = w_busy;
    assign ready    = w_ready;
    assign done     = (state_q == S_STOP);
    assign rx_valid = (state_q == S_STOP) && rd_q;
    assign rx_data  = rx_data_q;

endmodule
`default_nettype wire
